// File: rtl/bc_fir_seq.sv
// Time-multiplexed symmetric FIR: one folded tap pair per clock through a single pre-adder and multiplier.
// Optional macro BC_FIR_SEQ_ZERO_SKIP_EN: the MAC walk visits only nonzero coefficients.
//
// state | meaning
// IDLE  | waiting for a sample; coefficient writes accepted
// MAC   | accumulating one folded tap per edge
// DONE  | result presented, held until out_ready
module bc_fir_seq #(
    parameter int N    = 8,
    parameter int TAPS = 39
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    input  logic         cfg_we,
    input  logic [4:0]   cfg_addr,
    input  logic [N-1:0] cfg_data,
    output logic         cfg_err,
    output logic         busy
);
    localparam int HALF = (TAPS + 1) / 2;
    localparam int KW   = $clog2(HALF);
    localparam int XW   = $clog2(TAPS);

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  x_q [TAPS];
    logic [N-1:0]  x_d [TAPS];
    logic [N-1:0]  c_q [HALF];
    logic [N-1:0]  c_d [HALF];
    logic [N-1:0]  acc_q, acc_d;
    logic [KW-1:0] k_q, k_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          cfg_err_q, cfg_err_d;
    logic          busy_q, busy_d;

    logic          accept;
    logic          cfg_ok;
    logic          last;
    logic [XW-1:0] lo_idx, hi_idx;
    logic [N-1:0]  pre_add;
    logic [N-1:0]  product;
`ifdef BC_FIR_SEQ_ZERO_SKIP_EN
    logic [KW-1:0] k_first, k_next;
    logic          has_next;
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        c_d        = c_q;
        acc_d      = acc_q;
        k_d        = k_q;
        out_data_d = out_data_q;

        accept    = (state_q == IDLE) && in_ready_q && in_valid;
        cfg_ok    = cfg_we && (state_q == IDLE) && (cfg_addr < 5'(HALF));
        cfg_err_d = cfg_we && !cfg_ok;
        if (cfg_ok) begin
            c_d[cfg_addr] = cfg_data;
        end

        // Fold x[k] with its mirror x[TAPS-1-k]; the centre tap has no partner.
        lo_idx  = XW'(k_q);
        hi_idx  = XW'(TAPS - 1) - lo_idx;
        pre_add = (k_q == KW'(HALF - 1)) ? x_q[lo_idx] : x_q[lo_idx] + x_q[hi_idx];
        product = c_q[k_q] * pre_add;

`ifdef BC_FIR_SEQ_ZERO_SKIP_EN
        // Start index is searched in the post-write bank so a same-edge write counts.
        k_first = '0;
        for (int i = HALF - 1; i >= 0; i--) begin
            if (c_d[i] != '0) begin
                k_first = KW'(i);
            end
        end
        k_next   = '0;
        has_next = 1'b0;
        for (int i = HALF - 1; i >= 0; i--) begin
            if ((KW'(i) > k_q) && (c_q[i] != '0)) begin
                k_next   = KW'(i);
                has_next = 1'b1;
            end
        end
        last = !has_next;
`else
        last = (k_q == KW'(HALF - 1));
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    for (int i = TAPS - 1; i > 0; i--) begin
                        x_d[i] = x_q[i-1];
                    end
                    x_d[0] = in_data;
                    acc_d  = '0;
`ifdef BC_FIR_SEQ_ZERO_SKIP_EN
                    k_d    = k_first;
`else
                    k_d    = '0;
`endif
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + product;
                if (last) begin
                    out_data_d = acc_d;
                    state_d    = DONE;
                end else begin
`ifdef BC_FIR_SEQ_ZERO_SKIP_EN
                    k_d = k_next;
`else
                    k_d = k_q + 1'b1;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
            for (int i = 0; i < HALF; i++) begin
                c_q[i] <= '0;
            end
            acc_q       <= '0;
            k_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            c_q         <= c_d;
            acc_q       <= acc_d;
            k_q         <= k_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = busy_q;

endmodule
